// File: rtl/jtag_master_pkg.sv
// Shared types and TAP walk constants for the JTAG scan master.
// Each TMS sequence is stored with bit i = TMS level on TCK cycle i.
package jtag_master_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_t;

    localparam int INIT_TCKS   = 6;
    localparam int PRE_TCKS_DR = 3;
    localparam int PRE_TCKS_IR = 4;

    // RTI -> Select-DR -> Capture-DR -> Shift-DR, with Select-IR added for IR scans
    localparam logic [3:0] PRE_TMS_DR = 4'b0001;
    localparam logic [3:0] PRE_TMS_IR = 4'b0011;
    // Exit1 -> Update -> RTI
    localparam logic [1:0] POST_TMS   = 2'b01;

    function automatic logic pre_tms(input logic ir, input logic [1:0] idx);
        logic [3:0] seq;
        seq = ir ? PRE_TMS_IR : PRE_TMS_DR;
        return seq[idx];
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: low phase then high phase of CLK_DIV clocks each, with
// single-clock strobes on the clocks where TCK rises and falls.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_reg;
    logic          tck_reg;
    logic          phase_end;

    assign phase_end = enable && (cnt_reg == CW'(CLK_DIV - 1));
    assign rise_tick = phase_end && !tck_reg;
    assign fall_tick = phase_end && tck_reg;
    assign tck       = tck_reg;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (phase_end) begin
            cnt_reg <= '0;
            tck_reg <= ~tck_reg;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG initiator: walks the TAP from Run-Test/Idle through one IR or DR scan,
// shifting TDI LSB first and collecting TDO into scan_data_out.
module jtag_scan_master
    import jtag_master_pkg::*;
#(
    parameter  int CLK_DIV  = 2,
    parameter  int MAX_BITS = 32,
    localparam int LW       = $clog2(MAX_BITS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                scan_ir,
    input  logic [LW-1:0]       scan_length,
    input  logic [MAX_BITS-1:0] scan_data_in,
    output logic                busy,
    output logic                done,
    output logic [MAX_BITS-1:0] scan_data_out,
    output logic                TCK,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO
);

    // Step counter also walks INIT, so it needs at least 3 bits
    localparam int SW = (LW > 3) ? LW : 3;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BITS);

    state_t              state_reg, state_next;
    logic [SW-1:0]       step_reg, step_next;
    logic                ir_reg, ir_next;
    logic [LW-1:0]       len_reg, len_next;
    logic [MAX_BITS-1:0] din_reg, din_next;
    logic [MAX_BITS-1:0] cap_reg, cap_next;
    logic [MAX_BITS-1:0] dout_reg, dout_next;
    logic                tms_reg, tms_next;
    logic                tdi_reg, tdi_next;

    logic                tck_en, fall_tick, rise_tick;
    logic [LW-1:0]       len_sat;
    logic [SW-1:0]       step_inc, pre_last, shift_last;
    logic [MAX_BITS-1:0] din_shift;
    logic [LW-1:0]       align_shift;

    assign len_sat     = (scan_length > MAX_LEN) ? MAX_LEN : scan_length;
    assign step_inc    = step_reg + SW'(1);
    assign pre_last    = ir_reg ? SW'(PRE_TCKS_IR - 1) : SW'(PRE_TCKS_DR - 1);
    assign shift_last  = SW'(len_reg) - SW'(1);
    assign din_shift   = din_reg >> 1;
    assign align_shift = MAX_LEN - len_reg;

    // A zero-length scan passes through PRE without ever starting TCK
    assign tck_en = (state_reg == ST_INIT) || (state_reg == ST_SHIFT) ||
                    (state_reg == ST_POST) ||
                    ((state_reg == ST_PRE) && (len_reg != '0));

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (tck_en),
        .tck      (TCK),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        ir_next    = ir_reg;
        len_next   = len_reg;
        din_next   = din_reg;
        cap_next   = cap_reg;
        dout_next  = dout_reg;
        tms_next   = tms_reg;
        tdi_next   = tdi_reg;

        case (state_reg)
            ST_INIT: begin
                if (fall_tick) begin
                    if (step_reg == SW'(INIT_TCKS - 1)) begin
                        state_next = ST_IDLE;
                        step_next  = '0;
                        tms_next   = 1'b0;
                    end else begin
                        step_next = step_inc;
                        tms_next  = (step_inc != SW'(INIT_TCKS - 1));
                    end
                end
            end
            ST_IDLE: begin
                tms_next = 1'b0;
                tdi_next = 1'b0;
                if (start) begin
                    state_next = ST_PRE;
                    step_next  = '0;
                    ir_next    = scan_ir;
                    len_next   = len_sat;
                    din_next   = scan_data_in;
                    cap_next   = '0;
                    tms_next   = (len_sat != '0) && pre_tms(scan_ir, 2'd0);
                end
            end
            ST_PRE: begin
                if (len_reg == '0) begin
                    state_next = ST_DONE;
                    dout_next  = '0;
                    tms_next   = 1'b0;
                end else if (fall_tick) begin
                    if (step_reg == pre_last) begin
                        state_next = ST_SHIFT;
                        step_next  = '0;
                        tms_next   = (len_reg == LW'(1));
                        tdi_next   = din_reg[0];
                    end else begin
                        step_next = step_inc;
                        tms_next  = pre_tms(ir_reg, step_inc[1:0]);
                    end
                end
            end
            ST_SHIFT: begin
                // TDO enters at the top; the result is right-aligned at the end
                if (rise_tick) begin
                    cap_next = {TDO, cap_reg[MAX_BITS-1:1]};
                end
                if (fall_tick) begin
                    if (step_reg == shift_last) begin
                        state_next = ST_POST;
                        step_next  = '0;
                        tms_next   = POST_TMS[0];
                        tdi_next   = 1'b0;
                    end else begin
                        step_next = step_inc;
                        din_next  = din_shift;
                        tdi_next  = din_shift[0];
                        tms_next  = (step_inc == shift_last);
                    end
                end
            end
            ST_POST: begin
                if (fall_tick) begin
                    if (step_reg == SW'(1)) begin
                        state_next = ST_DONE;
                        step_next  = '0;
                        tms_next   = 1'b0;
                        dout_next  = cap_reg >> align_shift;
                    end else begin
                        step_next = step_inc;
                        tms_next  = POST_TMS[1];
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_INIT;
            step_reg  <= '0;
            ir_reg    <= 1'b0;
            len_reg   <= '0;
            din_reg   <= '0;
            cap_reg   <= '0;
            dout_reg  <= '0;
            tms_reg   <= 1'b1;
            tdi_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            ir_reg    <= ir_next;
            len_reg   <= len_next;
            din_reg   <= din_next;
            cap_reg   <= cap_next;
            dout_reg  <= dout_next;
            tms_reg   <= tms_next;
            tdi_reg   <= tdi_next;
        end
    end

    assign busy          = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done          = (state_reg == ST_DONE);
    assign scan_data_out = dout_reg;
    assign TMS           = tms_reg;
    assign TDI           = tdi_reg;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master against a behavioural TAP (4-bit IR capturing
// 0001, variable-length DR preset to 0x3C), with a scoreboard checked on done.
module tb_jtag_scan_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        scan_ir = 1'b0;
    logic [5:0]  scan_length = '0;
    logic [31:0] scan_data_in = '0;
    logic        busy, done;
    logic [31:0] scan_data_out;
    logic        TCK, TMS, TDI, TDO;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tck_rises = 0;
    int done_count = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    jtag_scan_master #(
        .CLK_DIV (2),
        .MAX_BITS(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .scan_ir      (scan_ir),
        .scan_length  (scan_length),
        .scan_data_in (scan_data_in),
        .busy         (busy),
        .done         (done),
        .scan_data_out(scan_data_out),
        .TCK          (TCK),
        .TMS          (TMS),
        .TDI          (TDI),
        .TDO          (TDO)
    );

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            UPIR:    return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    tap_t        tap_st = TLR;
    logic [31:0] dr_reg = 32'h0000_003C;
    logic [31:0] dr_sr  = '0;
    int          dr_cnt = 0;
    logic [3:0]  ir_reg = 4'h1;
    logic [3:0]  ir_sr  = '0;
    int          ir_cnt = 0;
    logic        tdo_q  = 1'b0;
    logic        tms_log[$];
    int          rise_cyc[$];

    assign TDO = tdo_q;

    always @(posedge TCK) begin
        case (tap_st)
            CAPDR: begin dr_sr <= dr_reg; dr_cnt <= 0; end
            SHDR: begin
                dr_sr <= {TDI, dr_sr[31:1]};
                if (dr_cnt < 32) dr_cnt <= dr_cnt + 1;
            end
            UPDR:  dr_reg <= dr_sr >> (32 - dr_cnt);
            CAPIR: begin ir_sr <= 4'b0001; ir_cnt <= 0; end
            SHIR: begin
                ir_sr <= {TDI, ir_sr[3:1]};
                if (ir_cnt < 4) ir_cnt <= ir_cnt + 1;
            end
            UPIR:  ir_reg <= ir_sr >> (4 - ir_cnt);
            default: ;
        endcase
        tap_st <= tap_next(tap_st, TMS);
        tck_rises <= tck_rises + 1;
        tms_log.push_back(TMS);
        rise_cyc.push_back(cyc);
    end

    always @(negedge TCK) begin
        tdo_q <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] dout;
        int          tcks;
        int          lat;
        int          start_cyc;
        int          base;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
            errors++;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done_count), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("scan_data_out", scan_data_out, e.dout);
                chk("tck_count", 32'(tck_rises - e.base), 32'(e.tcks));
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                if (e.lat >= 0) chk("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
            $display("scan done #%0d: data_out=0x%08h tcks=%0d", done_count, scan_data_out, tck_rises);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic ir, input logic [5:0] len, input logic [31:0] data,
                         input logic push, input logic [31:0] e_out, input int e_tcks,
                         input int e_lat);
        exp_t e;
        int n = 0;
        while (busy && n < 2000) begin @(negedge clock); n++; end
        chk("issue_idle", {31'b0, busy}, 32'd0);
        start = 1'b1; scan_ir = ir; scan_length = len; scan_data_in = data;
        e.dout = e_out; e.tcks = e_tcks; e.lat = e_lat; e.start_cyc = cyc; e.base = tck_rises;
        if (push) exp_q.push_back(e);
        $display("start: ir=%0d len=%0d data=0x%08h", ir, len, data);
        @(negedge clock);
        start = 1'b0; scan_ir = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin @(negedge clock); n++; end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tck"},  {31'b0, TCK},  32'd0);
        chk({tag, "_tms"},  {31'b0, TMS},  32'd1);
        chk({tag, "_tdi"},  {31'b0, TDI},  32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_dout"}, scan_data_out, 32'd0);
    endtask

    task automatic check_init(input string tag);
        int n = 0;
        int period;
        logic [5:0] tms_bits = '0;
        while (busy && n < 400) begin @(negedge clock); n++; end
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        chk({tag, "_tck_count"}, 32'(tms_log.size()), 32'd6);
        for (int i = 0; i < tms_log.size() && i < 6; i++) tms_bits[i] = tms_log[i];
        chk({tag, "_tms_seq"}, {26'b0, tms_bits}, 32'h1F);
        period = (rise_cyc.size() >= 2) ? (rise_cyc[1] - rise_cyc[0]) : -1;
        chk({tag, "_tck_period"}, 32'(period), 32'd4);
        chk({tag, "_tap_rti"}, {28'b0, tap_st}, {28'b0, RTI});
        $display("%s: %0d TCKs, TMS bits=%b, busy=%0d", tag, tms_log.size(), tms_bits, busy);
    endtask

    initial begin
        int r0;
        int n;

        // 1: reset values, then the INIT walk
        repeat (5) @(negedge clock);
        check_reset_outputs("reset");
        tms_log.delete(); rise_cyc.delete();
        reset = 1'b0;
        check_init("init");

        // 2: DR scan, len 8
        issue(1'b0, 6'd8, 32'hA5, 1'b1, 32'h0000_003C, 13, -1);
        wait_done(1000); @(negedge clock);
        chk("s2_done_single", {31'b0, done}, 32'd0);
        chk("s2_model_dr", dr_reg, 32'hA5);
        chk("s2_tap_rti", {28'b0, tap_st}, {28'b0, RTI});

        // 3: IR scan, len 4
        issue(1'b1, 6'd4, 32'h9, 1'b1, 32'h1, 10, -1);
        wait_done(1000); @(negedge clock);
        chk("s3_model_ir", {28'b0, ir_reg}, 32'h9);
        chk("s3_tap_rti", {28'b0, tap_st}, {28'b0, RTI});

        // 4: zero length, then oversize length
        issue(1'b0, 6'd0, 32'hFFFF_FFFF, 1'b1, 32'h0, 0, 2);
        wait_done(20); @(negedge clock);
        issue(1'b0, 6'd40, 32'h1234_5678, 1'b1, 32'h0000_00A5, 37, -1);
        wait_done(1000); @(negedge clock);
        chk("s4_model_dr", dr_reg, 32'h1234_5678);

        // 5: reload DR with 0x3C, then repeat scenario 2 with stray starts
        issue(1'b0, 6'd8, 32'h3C, 1'b1, 32'h0000_0078, 13, -1);
        wait_done(1000); @(negedge clock);
        r0 = tck_rises;
        issue(1'b0, 6'd8, 32'hA5, 1'b1, 32'h0000_003C, 13, -1);
        repeat (20) @(negedge clock);
        chk("s5_busy_mid", {31'b0, busy}, 32'd1);
        start = 1'b1; scan_ir = 1'b1; scan_length = 6'd3; scan_data_in = 32'hFFFF_FFFF;
        @(negedge clock);
        start = 1'b0; scan_ir = 1'b0;
        wait_done(1000);
        start = 1'b1; scan_ir = 1'b1; scan_length = 6'd5;
        @(negedge clock);
        start = 1'b0; scan_ir = 1'b0;
        chk("s5_idle_after_done", {31'b0, busy}, 32'd0);
        repeat (30) @(negedge clock);
        chk("s5_tck_total", 32'(tck_rises - r0), 32'd13);
        chk("s5_still_idle", {31'b0, busy}, 32'd0);
        chk("s5_model_dr", dr_reg, 32'hA5);
        chk("s5_done_count", 32'(done_count), 32'd6);

        // 6: reset during SHIFT bit 3 (7th TCK rise of the scan)
        r0 = tck_rises;
        issue(1'b0, 6'd8, 32'h08, 1'b0, 32'h0, 0, -1);
        n = 0;
        while ((tck_rises - r0) < 7 && n < 200) begin @(negedge clock); n++; end
        chk("s6_reached_bit3", 32'(tck_rises - r0), 32'd7);
        reset = 1'b1;
        tms_log.delete(); rise_cyc.delete();
        @(negedge clock);
        check_reset_outputs("s6_reset");
        reset = 1'b0;
        check_init("s6_init");
        issue(1'b0, 6'd16, 32'hBEEF, 1'b1, 32'h0000_0008, 21, -1);
        wait_done(1000); @(negedge clock);
        issue(1'b0, 6'd16, 32'h1234, 1'b1, 32'h0000_BEEF, 21, -1);
        wait_done(1000); @(negedge clock);
        chk("s6_model_dr", dr_reg, 32'h1234);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
